// File: rtl/lcd_field_formatter.sv
// Renders NUM_FIELDS numeric values as hex or decimal ASCII into two LCD row buffers.
// Fields are converted one at a time into shadow rows; both rows are published together on commit.
module lcd_field_formatter #(
   parameter int NUM_FIELDS = 4,
   parameter int VAL_W = 16,
   parameter int ROW_CHARS = 16,
   parameter logic [NUM_FIELDS-1:0] FIELD_ROW = '0,
   parameter logic [NUM_FIELDS*4-1:0] FIELD_COL = '0,
   parameter logic [NUM_FIELDS*3-1:0] FIELD_DIG = {NUM_FIELDS{3'd4}},
   parameter logic [7:0] INIT_CHAR = 8'h3F,
   parameter logic [7:0] BLANK_CHAR = 8'h20,
   parameter logic [7:0] OVF_CHAR = 8'h2A
) (
   input  logic clk,
   input  logic reset_n,
   input  logic refresh,
   input  logic [NUM_FIELDS*VAL_W-1:0] values,
   input  logic [NUM_FIELDS-1:0] dec_mode,
   input  logic [NUM_FIELDS-1:0] zpad,
   output logic [8*ROW_CHARS-1:0] row_A,
   output logic [8*ROW_CHARS-1:0] row_B,
   output logic busy,
   output logic done
);
   localparam int MAX_DIG = 7;
   localparam int BCD_D = (VAL_W * 302 + 999) / 1000 + 1;
   localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam int CNT_W = $clog2(VAL_W + 1);
   localparam int ROW_W = 8 * ROW_CHARS;

   if (NUM_FIELDS < 1 || NUM_FIELDS > (1 << IDX_W)) begin : g_bad_count
      $error("lcd_field_formatter: field index cannot address NUM_FIELDS fields");
   end

   for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_chk
      if (FIELD_DIG[3*g +: 3] == 3'd0) begin : g_bad_dig
         $error("lcd_field_formatter: field digit count must be 1..7");
      end
      if (int'(FIELD_COL[4*g +: 4]) + int'(FIELD_DIG[3*g +: 3]) > ROW_CHARS) begin : g_bad_col
         $error("lcd_field_formatter: field extends past the end of its row");
      end
   end

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_WRITE, S_COMMIT} state_t;

   state_t state;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic [VAL_W-1:0] shreg;
   logic [4*BCD_D-1:0] bcd;
   logic pending;
   logic [NUM_FIELDS*VAL_W-1:0] snap_val;
   logic [NUM_FIELDS-1:0] snap_dec;
   logic [NUM_FIELDS-1:0] snap_zpad;
   logic [ROW_W-1:0] sh_a;
   logic [ROW_W-1:0] sh_b;

   logic [2:0] cur_dig;
   logic [3:0] cur_col;
   logic cur_row;
   logic cur_dec;
   logic cur_zpad;
   logic last_field;
   logic ovf;
   logic lead;
   logic [4*(BCD_D+MAX_DIG)-1:0] bcd_pad;
   logic [VAL_W+4*MAX_DIG-1:0] hex_pad;
   logic [3:0] nib [MAX_DIG];
   logic [7:0] fch [MAX_DIG];
   logic [7:0] fpos [MAX_DIG];

   // One double-dabble step: add 3 to every digit >= 5, then shift the next value bit in.
   function automatic logic [4*BCD_D-1:0] dabble(input logic [4*BCD_D-1:0] b, input logic in_bit);
      logic [4*BCD_D-1:0] a;
      a = b;
      for (int d = 0; d < BCD_D; d++) begin
         if (a[4*d +: 4] >= 4'd5) a[4*d +: 4] = a[4*d +: 4] + 4'd3;
      end
      return {a[4*BCD_D-2:0], in_bit};
   endfunction

   // Characters of the field being written, digit k = 0 is least significant.
   always_comb begin
      cur_dig = FIELD_DIG[3*int'(idx) +: 3];
      cur_col = FIELD_COL[4*int'(idx) +: 4];
      cur_row = FIELD_ROW[idx];
      cur_dec = snap_dec[idx];
      cur_zpad = snap_zpad[idx];
      last_field = (int'(idx) == NUM_FIELDS - 1);
      bcd_pad = '0;
      bcd_pad[4*BCD_D-1:0] = bcd;
      hex_pad = '0;
      hex_pad[VAL_W-1:0] = shreg;
      ovf = 1'b0;
      for (int k = 0; k < BCD_D; k++) begin
         if (cur_dec && k >= int'(cur_dig) && bcd[4*k +: 4] != 4'd0) ovf = 1'b1;
      end
      lead = 1'b1;
      for (int k = MAX_DIG - 1; k >= 0; k--) begin
         nib[k] = cur_dec ? bcd_pad[4*k +: 4] : hex_pad[4*k +: 4];
         fch[k] = (nib[k] < 4'd10) ? 8'h30 + {4'd0, nib[k]} : 8'h37 + {4'd0, nib[k]};
         fpos[k] = 8'(int'(cur_col) + int'(cur_dig) - 1 - k);
         if (k < int'(cur_dig)) begin
            if (ovf) fch[k] = OVF_CHAR;
            else if (lead && nib[k] == 4'd0 && k != 0 && !cur_zpad) fch[k] = BLANK_CHAR;
            else lead = 1'b0;
         end
      end
   end

   // refresh is a one-cycle request; while busy it is folded into a single pending pass,
   // which starts one idle cycle after busy falls.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
         idx <= '0;
         cnt <= '0;
         shreg <= '0;
         bcd <= '0;
         pending <= 1'b0;
         snap_val <= '0;
         snap_dec <= '0;
         snap_zpad <= '0;
         sh_a <= {ROW_CHARS{INIT_CHAR}};
         sh_b <= {ROW_CHARS{INIT_CHAR}};
         row_A <= {ROW_CHARS{INIT_CHAR}};
         row_B <= {ROW_CHARS{INIT_CHAR}};
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (busy) begin
                  busy <= 1'b0;
                  pending <= pending | refresh;
               end else if (refresh || pending) begin
                  snap_val <= values;
                  snap_dec <= dec_mode;
                  snap_zpad <= zpad;
                  sh_a <= row_A;
                  sh_b <= row_B;
                  idx <= '0;
                  pending <= 1'b0;
                  busy <= 1'b1;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               shreg <= snap_val[VAL_W*int'(idx) +: VAL_W];
               bcd <= '0;
               cnt <= '0;
               state <= cur_dec ? S_CONV : S_WRITE;
            end
            S_CONV: begin
               bcd <= dabble(bcd, shreg[VAL_W-1]);
               shreg <= shreg << 1;
               cnt <= cnt + CNT_W'(1);
               if (int'(cnt) == VAL_W - 1) state <= S_WRITE;
            end
            S_WRITE: begin
               for (int k = 0; k < MAX_DIG; k++) begin
                  if (k < int'(cur_dig)) begin
                     if (cur_row) sh_b[8*(ROW_CHARS-1-int'(fpos[k])) +: 8] <= fch[k];
                     else sh_a[8*(ROW_CHARS-1-int'(fpos[k])) +: 8] <= fch[k];
                  end
               end
               idx <= idx + IDX_W'(1);
               state <= last_field ? S_COMMIT : S_LOAD;
            end
            S_COMMIT: begin
               row_A <= sh_a;
               row_B <= sh_b;
               done <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (state != S_IDLE && refresh) pending <= 1'b1;
      end
   end
endmodule

// File: tb/tb_lcd_field_formatter.sv
// Bench for lcd_field_formatter: a pass-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized refresh traffic.
module tb_lcd_field_formatter;
   localparam int NF = 4;
   localparam int VW = 16;
   localparam logic [3:0] F_ROW = 4'b1010;
   localparam logic [15:0] F_COL = {4'd8, 4'd6, 4'd6, 4'd0};
   localparam logic [11:0] F_DIG = {3'd4, 3'd7, 3'd5, 3'd2};
   localparam int M_ROW [4] = '{0, 1, 0, 1};
   localparam int M_COL [4] = '{0, 6, 6, 8};
   localparam int M_DIG [4] = '{2, 5, 7, 4};
   localparam logic [127:0] ALL_Q = {16{8'h3F}};

   logic clk;
   logic reset_n;
   logic refresh;
   logic [63:0] values;
   logic [3:0] dec_mode;
   logic [3:0] zpad;
   logic [127:0] row_A;
   logic [127:0] row_B;
   logic busy;
   logic done;

   int errors = 0;
   int checks = 0;

   lcd_field_formatter #(
      .NUM_FIELDS(NF), .VAL_W(VW), .ROW_CHARS(16),
      .FIELD_ROW(F_ROW), .FIELD_COL(F_COL), .FIELD_DIG(F_DIG),
      .INIT_CHAR(8'h3F), .BLANK_CHAR(8'h20), .OVF_CHAR(8'h2A)
   ) dut (
      .clk(clk), .reset_n(reset_n), .refresh(refresh), .values(values),
      .dec_mode(dec_mode), .zpad(zpad), .row_A(row_A), .row_B(row_B),
      .busy(busy), .done(done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // reference model
   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r *= 10;
      return r;
   endfunction

   function automatic int pass_len(input logic [3:0] dm);
      int t = 1;
      for (int i = 0; i < NF; i++) t += 2 + (dm[i] ? VW : 0);
      return t;
   endfunction

   function automatic void render(input logic [127:0] in_a, input logic [127:0] in_b,
                                  input logic [63:0] vals, input logic [3:0] dm,
                                  input logic [3:0] zp, output logic [127:0] out_a,
                                  output logic [127:0] out_b);
      out_a = in_a;
      out_b = in_b;
      for (int i = 0; i < NF; i++) begin
         int v;
         int n;
         int col;
         bit ovf;
         bit lead;
         logic [7:0] ch;
         v = vals[16*i +: 16];
         ovf = dm[i] && (v >= pow10(M_DIG[i]));
         lead = 1'b1;
         for (int k = M_DIG[i] - 1; k >= 0; k--) begin
            n = dm[i] ? (v / pow10(k)) % 10 : (v >> (4*k)) & 15;
            if (ovf) ch = "*";
            else if (lead && n == 0 && k > 0 && !zp[i]) ch = " ";
            else begin
               lead = 1'b0;
               ch = (n < 10) ? 8'(48 + n) : 8'(55 + n);
            end
            col = M_COL[i] + M_DIG[i] - 1 - k;
            if (M_ROW[i] == 1) out_b[8*(15-col) +: 8] = ch;
            else out_a[8*(15-col) +: 8] = ch;
         end
      end
   endfunction

   int cyc = 0;
   bit m_active;
   bit m_pend;
   int m_done_at;
   logic [127:0] exp_a, exp_b, nxt_a, nxt_b;
   logic exp_busy, exp_done;

   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         m_active = 1'b0;
         m_pend = 1'b0;
         exp_a = ALL_Q;
         exp_b = ALL_Q;
         exp_busy = 1'b0;
         exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (m_active) begin
            if (refresh) m_pend = 1'b1;
            if (cyc == m_done_at) begin
               exp_a = nxt_a;
               exp_b = nxt_b;
               exp_done = 1'b1;
            end else if (cyc == m_done_at + 1) begin
               m_active = 1'b0;
               exp_busy = 1'b0;
            end
         end else if (refresh || m_pend) begin
            render(exp_a, exp_b, values, dec_mode, zpad, nxt_a, nxt_b);
            m_done_at = cyc + pass_len(dec_mode);
            m_active = 1'b1;
            m_pend = 1'b0;
            exp_busy = 1'b1;
         end
      end
   end

   // scoreboard compare, every cycle
   always @(negedge clk) begin
      if (cyc > 0) begin
         check("row_A", row_A, exp_a);
         check("row_B", row_B, exp_b);
         check("busy", 128'(busy), 128'(exp_busy));
         check("done", 128'(done), 128'(exp_done));
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic run_until_idle(output int pulses, output logic [127:0] first_a,
                                 output logic [127:0] first_b);
      int quiet = 0;
      int n = 0;
      pulses = 0;
      first_a = '0;
      first_b = '0;
      while (quiet < 3 && n < 1000) begin
         @(negedge clk);
         n++;
         if (done) begin
            if (pulses == 0) begin
               first_a = row_A;
               first_b = row_B;
            end
            pulses++;
         end
         quiet = busy ? 0 : quiet + 1;
      end
      checks++;
      if (quiet < 3) begin
         errors++;
         $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
      end
   endtask

   function automatic logic [15:0] rand_val();
      case ($urandom_range(0, 4))
         0: return 16'($urandom_range(0, 9));
         1: return 16'($urandom_range(90, 110));
         2: return 16'($urandom_range(9990, 10010));
         3: return 16'($urandom_range(0, 65535));
         default: return 16'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      int p;
      int n;
      bit got;
      logic [127:0] fa, fb;
      reset_n = 1'b0;
      refresh = 1'b0;
      values = '0;
      dec_mode = '0;
      zpad = 4'hF;

      // reset
      tick(2);
      check("t1_row_A", row_A, ALL_Q);
      check("t1_row_B", row_B, ALL_Q);
      check("t1_busy", 128'(busy), 128'(0));
      check("t1_done", 128'(done), 128'(0));
      reset_n = 1'b1;
      tick(2);

      // hex, all-hex latency
      values = {16'h0000, 16'h0000, 16'h0000, 16'h003C};
      dec_mode = 4'b0000;
      zpad = 4'hF;
      refresh = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         refresh = 1'b0;
         n++;
         if (done) got = 1'b1;
      end
      check("t2_latency", 128'(n - 1), 128'(9));
      check("t2_hex", row_A[127:112], "3C");
      check("t2_untouched_a", row_A[111:80], "????");
      check("t2_untouched_b", row_B[127:80], "??????");
      run_until_idle(p, fa, fb);

      // decimal and blanking on field 3
      values = {16'd1234, 16'h0000, 16'h0000, 16'h0000};
      dec_mode = 4'b1000;
      pulse_refresh();
      run_until_idle(p, fa, fb);
      check("t3_pulses", 128'(p), 128'(1));
      check("t3_dec", row_B[63:32], "1234");
      values[63:48] = 16'd7;
      zpad = 4'b0111;
      pulse_refresh();
      run_until_idle(p, fa, fb);
      check("t3_blank7", row_B[63:32], "   7");
      values[63:48] = 16'd0;
      pulse_refresh();
      run_until_idle(p, fa, fb);
      check("t3_blank0", row_B[63:32], "   0");

      // overflow, hex truncation, overlap
      values = {16'd12345, 16'h0000, 16'hABCD, 16'h01A5};
      zpad = 4'hF;
      pulse_refresh();
      run_until_idle(p, fa, fb);
      check("t4_ovf", row_B[63:32], "****");
      check("t4_hex_trunc", row_A[127:112], "A5");
      check("t4_overlap", row_B[79:64], "0A");

      // pending: two requests -> two passes, first shows the first snapshot
      values = {16'd1111, 16'h0000, 16'h0000, 16'h0000};
      pulse_refresh();
      tick(4);
      values[63:48] = 16'd2222;
      pulse_refresh();
      run_until_idle(p, fa, fb);
      check("t5_pulses", 128'(p), 128'(2));
      check("t5_first", fb[63:32], "1111");
      check("t5_final", row_B[63:32], "2222");
      values[63:48] = 16'd3333;
      pulse_refresh();
      tick(2);
      pulse_refresh();
      tick(1);
      pulse_refresh();
      tick(1);
      pulse_refresh();
      run_until_idle(p, fa, fb);
      check("t5_merge_pulses", 128'(p), 128'(2));
      check("t5_merge_final", row_B[63:32], "3333");

      // reset mid-conversion
      dec_mode = 4'b1111;
      values = {16'd4321, 16'd100, 16'd65535, 16'd42};
      pulse_refresh();
      tick(6);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      check("t6_row_A", row_A, ALL_Q);
      check("t6_row_B", row_B, ALL_Q);
      check("t6_busy", 128'(busy), 128'(0));
      run_until_idle(p, fa, fb);
      check("t6_no_done", 128'(p), 128'(0));
      pulse_refresh();
      run_until_idle(p, fa, fb);
      check("t6_recover", 128'(p), 128'(1));
      check("t6_dec_ovf", row_A[127:112], "42");

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         values = {rand_val(), rand_val(), rand_val(), rand_val()};
         dec_mode = 4'($urandom_range(0, 15));
         zpad = 4'($urandom_range(0, 15));
         pulse_refresh();
         case ($urandom_range(0, 3))
            0: tick(1);
            1: begin
               tick($urandom_range(1, 40));
               values = {rand_val(), rand_val(), rand_val(), rand_val()};
               pulse_refresh();
            end
            2: begin
               tick($urandom_range(1, 20));
               values = {rand_val(), rand_val(), rand_val(), rand_val()};
               dec_mode = 4'($urandom_range(0, 15));
            end
            default: begin
               tick($urandom_range(1, 60));
               pulse_refresh();
               tick(1);
               pulse_refresh();
            end
         endcase
         run_until_idle(p, fa, fb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
